// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: runs the req/ready read of instruction memory for the
// current PC and captures the returned word, with PC+4, into the IF/ID register.
module if_fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] PC_INCR   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        stall_id,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus_4,
  output logic        if_id_valid,
  output logic        fetch_busy,
  output logic [1:0]  dbg_state
);

  // Handshake: imem_req rises with imem_addr = addr_q; both stay constant until the
  // cycle imem_ready=1, which completes the read. A request is never withdrawn
  // (flush parks in DROP); only reset abandons it.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] skid_q;
  logic [31:0] next_addr;
  logic [31:0] load_word;
  logic        accept;

  assign next_addr = addr_q + PC_INCR;
  assign load_word = (state_q == HOLD) ? skid_q : imem_rdata;
  assign accept    = !stall_id && !flush &&
                     (((state_q == REQ) && imem_ready) || (state_q == HOLD));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: if (!flush) state_d = REQ;
      REQ: begin
        if (flush)                      state_d = imem_ready ? LOAD : DROP;
        else if (imem_ready && stall_id) state_d = HOLD;
      end
      HOLD: if (flush) state_d = LOAD;
            else if (!stall_id) state_d = REQ;
      DROP: if (imem_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == REQ) || (state_q == DROP);
    imem_addr  = addr_q;
    fetch_busy = !accept;
    dbg_state  = state_q;
  end

  // addr_q tracks pc_in: loaded in LOAD, then stepped on each accepted word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      skid_q <= '0;
    end else begin
      if ((state_q == LOAD) && !flush) addr_q <= pc_in;
      else if (accept)                 addr_q <= next_addr;
      if ((state_q == REQ) && imem_ready && stall_id && !flush) skid_q <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_instr     <= NOP_INSTR;
      if_id_pc_plus_4 <= '0;
      if_id_valid     <= 1'b0;
    end else if (flush) begin
      if_id_instr     <= NOP_INSTR;
      if_id_pc_plus_4 <= '0;
      if_id_valid     <= 1'b0;
    end else if (stall_id) begin
      if_id_instr     <= if_id_instr;
      if_id_pc_plus_4 <= if_id_pc_plus_4;
      if_id_valid     <= if_id_valid;
    end else if (accept) begin
      if_id_instr     <= load_word;
      if_id_pc_plus_4 <= next_addr;
      if_id_valid     <= 1'b1;
    end else begin
      if_id_instr     <= NOP_INSTR;
      if_id_valid     <= 1'b0;
    end
  end

endmodule
